apb_addr_dec_v2: RTL and testbench
==================================

Name: apb_addr_dec_v2

Overview:
APB address decoder for the interconnect (apb_intercon_s master side). It slices a slave-select field addr[MSB:LSB] from the active master address and drives a one-hot PSEL vector, one bit per slave slot. It optionally qualifies the decode with an enable and an upper-address region match, and flags unpopulated or out-of-region accesses. Combinational outputs feed M_PSELx directly; registered copies and a sticky miss flag serve response muxing and debug.

Parameters:
ADDR_WIDTH, 16, width of addr.
MSB, 7, top bit of the slave-select field; must be < ADDR_WIDTH.
LSB, 4, bottom bit of the field; must be <= MSB.
MASK_RANGE, 2**(MSB-LSB+1), number of pselx bits; derived, never overridden.
N_SLAVES, MASK_RANGE, populated slots (1..MASK_RANGE); field values >= N_SLAVES are misses.
BASE_MASK, 0, ADDR_WIDTH mask of addr bits outside [MSB:LSB] that must match; 0 disables the region check.
BASE_MATCH, 0, required value of addr & BASE_MASK.

Ports:
clk  in  1  clock; all flops on rising edge.
reset  in  1  asynchronous, active-low reset.
addr  in  ADDR_WIDTH  address from the active master (PADDR).
en  in  1  decode qualifier (master PSEL); tie to 1 for pure address decode.
clr_sticky  in  1  synchronous clear of miss_sticky.
pselx  out  MASK_RANGE  combinational one-hot slave select.
sel_idx  out  clog2(MASK_RANGE) (min 1)  combinational field value addr[MSB:LSB].
hit  out  1  combinational: pselx nonzero.
miss  out  1  combinational: en and (region mismatch or field >= N_SLAVES).
pselx_q  out  MASK_RANGE  pselx registered.
sel_idx_q  out  clog2(MASK_RANGE)  sel_idx registered.
miss_sticky  out  1  latched miss.

Behaviour:
- field = addr[MSB:LSB]; region_ok = ((addr & BASE_MASK) == (BASE_MATCH & BASE_MASK)).
- pselx[p] = en & region_ok & (field == p) & (p < N_SLAVES), for each p in 0..MASK_RANGE-1. At most one bit is set.
- sel_idx = field always, independent of en.
- hit = |pselx. miss = en & ~hit. When en=0, hit=0 and miss=0.
- Combinational path: zero latency, no dependence on clk or reset.
- Each rising clk: pselx_q <= pselx; sel_idx_q <= sel_idx. Latency 1 cycle.
- miss_sticky: set on a clk edge when miss=1; cleared on an edge when clr_sticky=1 and miss=0. If both are 1 on the same edge, set wins.
- reset low: pselx_q=0, sel_idx_q=0, miss_sticky=0 immediately (asynchronous). Reset has no effect on the combinational outputs.
- Elaboration error if MSB >= ADDR_WIDTH, LSB > MSB, N_SLAVES < 1, or N_SLAVES > MASK_RANGE.
- With en=1 and default parameters the block is a pure addr[MSB:LSB] to one-hot decoder.

Decomposition:
- Shared package or include: clog2 macro (existing clog2.v) and a MASK_RANGE calculation function. The interconnect reuses the same address-field constants (ADDR_MSB/ADDR_LSB defaults 7/4) from vmicro16_soc_config.v.
- One natural sub-module: apb_addr_onehot, a pure combinational field-to-one-hot decoder with a generate loop and N_SLAVES gating. The top level adds region match, en qualification, registers and the sticky flag.

Test Plan:
- Defaults, en=1, addr=0x0035 -> pselx=0x0008, sel_idx=3, hit=1, miss=0; after the next clk, pselx_q=0x0008 and sel_idx_q=3.
- Sweep addr 0x0000..0x00F0 in steps of 0x10, en=1 -> pselx=1<<i each step, exactly one bit set; bits [3:0] and [15:8] of addr have no effect.
- en=0, addr=0x0035 -> pselx=0, hit=0, miss=0; miss_sticky stays 0.
- N_SLAVES=10, addr=0x00C0, en=1 -> pselx=0, miss=1, miss_sticky=1 after the edge; it holds until clr_sticky=1 with miss=0; with clr_sticky and miss both 1 it stays 1.
- BASE_MASK=0xFF00, BASE_MATCH=0x8000: addr=0x8020 -> pselx=0x0004, hit=1; addr=0x4020 -> pselx=0, miss=1.
- Drive reset low mid-traffic between clock edges -> pselx_q, sel_idx_q and miss_sticky go to 0 immediately while pselx still follows addr. Release reset -> registers update normally on the next edge.

Source files
------------

// File: rtl/apb_addr_dec_v2_pkg.sv
// Shared constants and helpers for the APB slave-select address decoder.
// The interconnect uses the same ADDR_MSB/ADDR_LSB field defaults.
package apb_addr_dec_v2_pkg;

  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 4;

  // Number of slave slots addressable by a field addr[msb:lsb].
  function automatic int calc_mask_range(input int msb, input int lsb);
    return 1 << (msb - lsb + 1);
  endfunction

  // Ceiling log2, never less than 1 so index ports keep a legal width.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/apb_addr_onehot.sv
// Combinational field-to-one-hot decoder; slots at or above N_SLAVES never select.
module apb_addr_onehot #(
  parameter int FIELD_W    = 4,
  parameter int MASK_RANGE = 16,
  parameter int N_SLAVES   = 16
) (
  input  logic [FIELD_W-1:0]    field,
  input  logic                  enable,
  output logic [MASK_RANGE-1:0] onehot
);

  for (genvar p = 0; p < MASK_RANGE; p++) begin : g_slot
    if (p < N_SLAVES) begin : g_populated
      assign onehot[p] = enable & (field == FIELD_W'(p));
    end else begin : g_empty
      assign onehot[p] = 1'b0;
    end
  end

endmodule

// File: rtl/apb_addr_dec_v2.sv
// APB address decoder: region/enable-qualified one-hot PSEL, registered copies
// for response muxing, and a sticky miss flag for debug.
module apb_addr_dec_v2
  import apb_addr_dec_v2_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MSB        = ADDR_MSB,
  parameter int LSB        = ADDR_LSB,
  localparam int MASK_RANGE = calc_mask_range(MSB, LSB),
  parameter int N_SLAVES   = MASK_RANGE,
  parameter logic [ADDR_WIDTH-1:0] BASE_MASK  = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_MATCH = '0,
  localparam int SEL_W = clog2_min1(MASK_RANGE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  en,
  input  logic                  clr_sticky,
  output logic [MASK_RANGE-1:0] pselx,
  output logic [SEL_W-1:0]      sel_idx,
  output logic                  hit,
  output logic                  miss,
  output logic [MASK_RANGE-1:0] pselx_q,
  output logic [SEL_W-1:0]      sel_idx_q,
  output logic                  miss_sticky
);

  if (MSB >= ADDR_WIDTH || LSB > MSB || N_SLAVES < 1 || N_SLAVES > MASK_RANGE) begin : g_param_err
    $error("apb_addr_dec_v2: illegal MSB/LSB/N_SLAVES combination");
  end

  logic region_ok;

  // A zero BASE_MASK makes the region compare trivially true.
  assign region_ok = ((addr & BASE_MASK) == (BASE_MATCH & BASE_MASK));
  assign sel_idx   = addr[MSB:LSB];

  apb_addr_onehot #(
    .FIELD_W    (SEL_W),
    .MASK_RANGE (MASK_RANGE),
    .N_SLAVES   (N_SLAVES)
  ) u_onehot (
    .field  (sel_idx),
    .enable (en & region_ok),
    .onehot (pselx)
  );

  assign hit  = |pselx;
  assign miss = en & ~hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pselx_q   <= '0;
      sel_idx_q <= '0;
    end else begin
      pselx_q   <= pselx;
      sel_idx_q <= sel_idx;
    end
  end

  // A new miss takes priority over a clear arriving on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_sticky <= 1'b0;
    end else if (miss) begin
      miss_sticky <= 1'b1;
    end else if (clr_sticky) begin
      miss_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_addr_dec_v2.sv
// Randomized scoreboard bench for apb_addr_dec_v2 across three parameter sets.
module tb_apb_addr_dec_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        clr_sticky;
  logic [15:0] addr;

  logic [15:0] psel [3];
  logic [3:0]  idx  [3];
  logic        hit  [3];
  logic        miss [3];
  logic [15:0] pq   [3];
  logic [3:0]  iq   [3];
  logic        st   [3];

  // instance 0: defaults; 1: ten populated slots; 2: region 0x80xx only
  int          n_sl   [3] = '{16, 10, 16};
  logic [15:0] bmask  [3] = '{16'h0000, 16'h0000, 16'hFF00};
  logic [15:0] bmatch [3] = '{16'h0000, 16'h0000, 16'h8000};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_addr_dec_v2 u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .clr_sticky(clr_sticky),
    .pselx(psel[0]), .sel_idx(idx[0]), .hit(hit[0]), .miss(miss[0]),
    .pselx_q(pq[0]), .sel_idx_q(iq[0]), .miss_sticky(st[0]));

  apb_addr_dec_v2 #(.N_SLAVES(10)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .clr_sticky(clr_sticky),
    .pselx(psel[1]), .sel_idx(idx[1]), .hit(hit[1]), .miss(miss[1]),
    .pselx_q(pq[1]), .sel_idx_q(iq[1]), .miss_sticky(st[1]));

  apb_addr_dec_v2 #(.BASE_MASK(16'hFF00), .BASE_MATCH(16'h8000)) u_dut2 (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .clr_sticky(clr_sticky),
    .pselx(psel[2]), .sel_idx(idx[2]), .hit(hit[2]), .miss(miss[2]),
    .pselx_q(pq[2]), .sel_idx_q(iq[2]), .miss_sticky(st[2]));

  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] psel;
    logic [3:0]  idx;
    logic        hit;
    logic        miss;
    logic [15:0] pq;
    logic [3:0]  iq;
    logic        st;
  } exp_t;

  exp_t sb [$];

  // reference model state
  logic [15:0] m_pq [3];
  logic [3:0]  m_iq;
  logic        m_st [3];
  logic [15:0] cur_a;
  logic        cur_e;
  logic        cur_c;

  function automatic logic [15:0] m_psel(input int k, input logic [15:0] a, input logic e);
    logic [15:0] one;
    int f;
    one = 16'd1;
    f = int'(a[7:4]);
    if (!e) return 16'h0;
    if ((a & bmask[k]) != (bmatch[k] & bmask[k])) return 16'h0;
    if (f >= n_sl[k]) return 16'h0;
    return one << f;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Model the register update at a rising edge from the inputs held over the last cycle.
  task automatic model_edge();
    logic [15:0] p;
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        m_pq[k] = 16'h0;
        m_st[k] = 1'b0;
      end else begin
        p = m_psel(k, cur_a, cur_e);
        m_pq[k] = p;
        if (cur_e && p == 16'h0) m_st[k] = 1'b1;
        else if (cur_c) m_st[k] = 1'b0;
      end
    end
    m_iq = reset ? cur_a[7:4] : 4'h0;
  endtask

  task automatic step(input logic [15:0] a, input logic e, input logic c);
    exp_t x;
    logic [15:0] p;
    @(posedge clk);
    model_edge();
    #2;
    addr = a; en = e; clr_sticky = c;
    cur_a = a; cur_e = e; cur_c = c;
    for (int k = 0; k < 3; k++) begin
      p = m_psel(k, a, e);
      x.k = 2'(k); x.psel = p; x.idx = a[7:4];
      x.hit = (p != 16'h0); x.miss = e && (p == 16'h0);
      x.pq = m_pq[k]; x.iq = m_iq; x.st = m_st[k];
      sb.push_back(x);
    end
  endtask

  // Called right after step(): moves to mid-cycle (after the negedge) and changes reset.
  task automatic rst_mid(input logic v);
    #5;
    reset = v;
    #1;
    if (!v) begin
      for (int k = 0; k < 3; k++) begin
        m_pq[k] = 16'h0;
        m_st[k] = 1'b0;
        chk("async_rst_pselx_q", k, 32'(pq[k]), 32'h0);
        chk("async_rst_sel_idx_q", k, 32'(iq[k]), 32'h0);
        chk("async_rst_sticky", k, 32'(st[k]), 32'h0);
        chk("rst_comb_pselx", k, 32'(psel[k]), 32'(m_psel(k, cur_a, cur_e)));
      end
      m_iq = 4'h0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pselx", int'(e.k), 32'(psel[e.k]), 32'(e.psel));
      chk("sel_idx", int'(e.k), 32'(idx[e.k]), 32'(e.idx));
      chk("hit", int'(e.k), 32'(hit[e.k]), 32'(e.hit));
      chk("miss", int'(e.k), 32'(miss[e.k]), 32'(e.miss));
      chk("pselx_q", int'(e.k), 32'(pq[e.k]), 32'(e.pq));
      chk("sel_idx_q", int'(e.k), 32'(iq[e.k]), 32'(e.iq));
      chk("miss_sticky", int'(e.k), 32'(st[e.k]), 32'(e.st));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    reset = 1'b0; en = 1'b0; clr_sticky = 1'b0; addr = 16'h0;
    cur_a = 16'h0; cur_e = 1'b0; cur_c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_pq[k] = 16'h0;
      m_st[k] = 1'b0;
    end
    m_iq = 4'h0;

    step(16'h0000, 1'b0, 1'b0);
    step(16'h0035, 1'b1, 1'b0);
    rst_mid(1'b1);
    step(16'h0035, 1'b1, 1'b0);
    step(16'h0035, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      a[7:4] = 4'(i);
      step(a, 1'b1, 1'b0);
    end

    step(16'h0035, 1'b0, 1'b0);
    step(16'h0035, 1'b0, 1'b1);

    step(16'h00C0, 1'b1, 1'b0);
    step(16'h00C0, 1'b1, 1'b1);
    step(16'h0010, 1'b0, 1'b0);
    step(16'h0010, 1'b1, 1'b1);
    step(16'h0010, 1'b1, 1'b0);

    step(16'h8020, 1'b1, 1'b0);
    step(16'h4020, 1'b1, 1'b0);
    step(16'h8020, 1'b1, 1'b1);
    step(16'h8020, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      if ($urandom_range(1, 0) == 1) a[15:8] = 8'h80;
      step(a, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) == 0));
    end
    step(16'h00D5, 1'b1, 1'b0);
    rst_mid(1'b0);
    step(16'h8040, 1'b1, 1'b0);
    step(16'h00E0, 1'b1, 1'b1);
    rst_mid(1'b1);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      if ($urandom_range(1, 0) == 1) a[15:8] = 8'h80;
      step(a, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) == 0));
    end
    step(16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
